// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } arb_state_t;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam int unsigned DEF_MAX_DSTREAK = 2;
    localparam int unsigned DEF_TIMEOUT     = 255;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: counts stalled memory cycles and flags when TIMEOUT is reached.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT));

    // Holds at TIMEOUT once reached so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port with a bounded
// data streak and a watchdog that aborts stalled transactions.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = DEF_MAX_DSTREAK,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_write,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack_n,
    output logic        err
);

    localparam int unsigned SW = cnt_width(MAX_DSTREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

    arb_state_t    r_state;
    arb_state_t    w_next;
    logic [SW-1:0] r_dstreak;
    logic [SW-1:0] w_dstreak_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_we;
    logic          r_err;

    logic w_busy;
    logic w_mem_ack;
    logic w_expired;
    logic w_timeout;
    logic w_done;
    logic w_fetch_wins;
    logic w_grant_i;
    logic w_grant_d;
    logic w_ack_i;
    logic w_ack_d;

    assign w_busy       = (r_state != IDLE);
    assign w_mem_ack    = w_busy && !mem_ack_n;
    // A memory ack in the expiry cycle wins over the abort.
    assign w_timeout    = w_busy && mem_ack_n && w_expired;
    assign w_done       = w_mem_ack || w_timeout;
    assign w_fetch_wins = if_req && (r_dstreak == STREAK_MAX);
    assign w_grant_i    = (r_state == IDLE) && if_req && (!d_req || w_fetch_wins);
    assign w_grant_d    = (r_state == IDLE) && d_req && !w_fetch_wins;

    mem_arb_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_grant_i || w_grant_d),
        .i_inc    (w_busy && mem_ack_n),
        .o_expired(w_expired)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = DBUSY;
                end else if (w_grant_i) begin
                    w_next = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (w_done) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_dstreak_next = r_dstreak;
        if (w_grant_i) begin
            w_dstreak_next = '0;
        end else if (w_grant_d) begin
            if (!if_req) begin
                w_dstreak_next = '0;
            end else if (r_dstreak != STREAK_MAX) begin
                w_dstreak_next = r_dstreak + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dstreak <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_size    <= SIZE_WORD;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dstreak <= w_dstreak_next;
            if (w_grant_d) begin
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                r_size  <= d_size;
                r_we    <= d_we;
            end else if (w_grant_i) begin
                r_addr  <= if_addr;
                r_wdata <= '0;
                r_size  <= SIZE_WORD;
                r_we    <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Acks and memory-side outputs are forced low while reset is held.
    assign w_ack_i = rst_n && (r_state == IBUSY) && w_done;
    assign w_ack_d = rst_n && (r_state == DBUSY) && w_done;

    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_size  = SIZE_WORD;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = w_ack_i;
        d_ack     = w_ack_d;
        if_rdata  = '0;
        d_rdata   = '0;
        if (rst_n) begin
            mem_req   = w_busy;
            mem_write = r_we;
            mem_size  = r_size;
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
        end
        if (w_ack_i && w_mem_ack) begin
            if_rdata = mem_rdata;
        end
        if (w_ack_d && w_mem_ack) begin
            d_rdata = mem_rdata;
        end
    end

    assign err = r_err;

endmodule
